// File: rtl/bank_port_arbiter_pkg.sv
// ============================================================================
// Module      : bank_port_arbiter_pkg
// Description : Shared constants and types for the AoC day-4 grid bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bank_port_arbiter_pkg;

    localparam int MAX_COLS        = 140;
    localparam int TX_DATA_WIDTH   = 32;
    localparam int BANK_DEPTH      = 140;
    localparam int BANK_ADDR_WIDTH = 8;
    localparam int COL_ADDR_WIDTH  = 8;

    typedef enum logic [1:0] {
        OP_RD_ROW = 2'd0,
        OP_WR_SEG = 2'd1,
        OP_WR_ROW = 2'd2
    } mem_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_t;

    typedef struct packed {
        mem_op_t                      op;
        logic [BANK_ADDR_WIDTH-1:0]   row;
        logic [COL_ADDR_WIDTH-1:0]    col;
        logic [MAX_COLS-1:0]          wdata;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/bank_port_arbiter_seg_merge.sv
// ============================================================================
// Module      : seg_merge
// Description : Overlays a TX_W-bit segment onto a row at a column offset;
//               segment bits that land at or above ROW_W are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_merge
    import bank_port_arbiter_pkg::*;
#(
    parameter int ROW_W = MAX_COLS,
    parameter int TX_W  = TX_DATA_WIDTH,
    parameter int CW    = COL_ADDR_WIDTH
) (
    input  logic [ROW_W-1:0] i_row,
    input  logic [TX_W-1:0]  i_seg,
    input  logic [CW-1:0]    i_col,
    output logic [ROW_W-1:0] o_merged
);

    // Shift in a ROW_W+TX_W wide space so the tail segment truncates cleanly.
    assign o_merged = (i_row & ~ROW_W'({{ROW_W{1'b0}}, {TX_W{1'b1}}} << i_col))
                    | ROW_W'({{ROW_W{1'b0}}, i_seg} << i_col);

endmodule

`default_nettype wire

// File: rtl/bank_port_arbiter.sv
// ============================================================================
// Module      : bank_port_arbiter
// Description : Two-port arbiter for the single-port grid bank; turns segment
//               writes into read-modify-write and serves full-row access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_port_arbiter
    import bank_port_arbiter_pkg::*;
#(
    parameter int ROW_W = MAX_COLS,
    parameter int TX_W  = TX_DATA_WIDTH,
    parameter int DEPTH = BANK_DEPTH,
    parameter int AW    = BANK_ADDR_WIDTH,
    parameter int CW    = COL_ADDR_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pad_en,
    input  logic             p0_valid,
    input  logic [1:0]       p0_op,
    input  logic [AW-1:0]    p0_row,
    input  logic [CW-1:0]    p0_col,
    input  logic [ROW_W-1:0] p0_wdata,
    output logic             p0_ack,
    output logic             p0_err,
    output logic [ROW_W-1:0] p0_rdata,
    input  logic             p1_valid,
    input  logic [1:0]       p1_op,
    input  logic [AW-1:0]    p1_row,
    input  logic [CW-1:0]    p1_col,
    input  logic [ROW_W-1:0] p1_wdata,
    output logic             p1_ack,
    output logic             p1_err,
    output logic [ROW_W-1:0] p1_rdata,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_re,
    output logic             mem_we,
    output logic [ROW_W-1:0] mem_wdata,
    input  logic [ROW_W-1:0] mem_rdata,
    output logic             busy_out
);

    arb_state_t       state_q, state_d;
    logic             grant_q, grant_d;
    mem_op_t          op_q, op_d;
    logic [AW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [ROW_W-1:0] wdata_q, wdata_d;
    logic             err_q, err_d;

    logic             mem_re_q, mem_re_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [ROW_W-1:0] mem_wdata_q, mem_wdata_d;
    logic             p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
    logic             p0_err_q, p0_err_d, p1_err_q, p1_err_d;
    logic [ROW_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic             busy_q, busy_d;

    logic             w_pick_pad;
    mem_op_t          w_req_op;
    logic [AW-1:0]    w_req_row;
    logic [CW-1:0]    w_req_col;
    logic [ROW_W-1:0] w_req_wdata;
    logic             w_req_bad;
    logic [ROW_W-1:0] w_merged;

    seg_merge #(
        .ROW_W (ROW_W),
        .TX_W  (TX_W),
        .CW    (CW)
    ) u_seg_merge (
        .i_row    (mem_rdata),
        .i_seg    (wdata_q[TX_W-1:0]),
        .i_col    (col_q),
        .o_merged (w_merged)
    );

    always_comb begin
        w_pick_pad  = p0_valid && (pad_en || !p1_valid);
        w_req_op    = w_pick_pad ? mem_op_t'(p0_op) : mem_op_t'(p1_op);
        w_req_row   = w_pick_pad ? p0_row   : p1_row;
        w_req_col   = w_pick_pad ? p0_col   : p1_col;
        w_req_wdata = w_pick_pad ? p0_wdata : p1_wdata;
        w_req_bad   = (int'(w_req_row) >= DEPTH)
                   || ((w_req_op == OP_WR_SEG)
                       && (((int'(w_req_col) % TX_W) != 0) || (int'(w_req_col) >= ROW_W)));
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        op_d        = op_q;
        row_d       = row_q;
        col_d       = col_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
        p0_err_d    = 1'b0;
        p1_err_d    = 1'b0;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (p0_valid || p1_valid) begin
                    grant_d = !w_pick_pad;
                    op_d    = w_req_op;
                    row_d   = w_req_row;
                    col_d   = w_req_col;
                    wdata_d = w_req_wdata;
                    err_d   = w_req_bad;
                    if (w_req_bad)
                        state_d = ST_DONE;
                    else if (w_req_op == OP_WR_ROW)
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD: state_d = ST_MERGE;
            ST_MERGE: begin
                if (op_q == OP_WR_SEG) begin
                    mem_wdata_d = w_merged;
                    state_d     = ST_WR;
                end else begin
                    if (grant_q)
                        p1_rdata_d = mem_rdata;
                    else
                        p0_rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        if (state_d == ST_RD) begin
            mem_re_d   = 1'b1;
            mem_addr_d = row_d;
        end
        if (state_d == ST_WR) begin
            mem_we_d   = 1'b1;
            mem_addr_d = row_d;
            if (op_d == OP_WR_ROW)
                mem_wdata_d = wdata_d;
        end
        if (state_d == ST_DONE) begin
            if (grant_d) begin
                p1_ack_d = 1'b1;
                p1_err_d = err_d;
            end else begin
                p0_ack_d = 1'b1;
                p0_err_d = err_d;
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b0;
            op_q        <= OP_RD_ROW;
            row_q       <= '0;
            col_q       <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            op_q        <= op_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
            p0_err_q    <= p0_err_d;
            p1_err_q    <= p1_err_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign busy_out  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bank_port_arbiter.sv
// ============================================================================
// Module      : tb_bank_port_arbiter
// Description : Directed self-checking bench for bank_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bank_port_arbiter;
    import bank_port_arbiter_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         pad_en = 1'b1;
    logic         p0_valid = 1'b0;
    logic [1:0]   p0_op = 2'd0;
    logic [7:0]   p0_row = 8'd0;
    logic [7:0]   p0_col = 8'd0;
    logic [139:0] p0_wdata = '0;
    logic         p0_ack, p0_err;
    logic [139:0] p0_rdata;
    logic         p1_valid = 1'b0;
    logic [1:0]   p1_op = 2'd0;
    logic [7:0]   p1_row = 8'd0;
    logic [7:0]   p1_col = 8'd0;
    logic [139:0] p1_wdata = '0;
    logic         p1_ack, p1_err;
    logic [139:0] p1_rdata;
    logic [7:0]   mem_addr;
    logic         mem_re, mem_we;
    logic [139:0] mem_wdata;
    logic [139:0] mem_rdata = '0;
    logic         busy_out;

    logic [139:0] bank [0:139] = '{default: '0};
    logic [139:0] exp_mem [0:139];
    int           checks = 0;
    int           errors = 0;
    int           we_count = 0;
    int           re_count = 0;

    bank_port_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .pad_en    (pad_en),
        .p0_valid  (p0_valid),
        .p0_op     (p0_op),
        .p0_row    (p0_row),
        .p0_col    (p0_col),
        .p0_wdata  (p0_wdata),
        .p0_ack    (p0_ack),
        .p0_err    (p0_err),
        .p0_rdata  (p0_rdata),
        .p1_valid  (p1_valid),
        .p1_op     (p1_op),
        .p1_row    (p1_row),
        .p1_col    (p1_col),
        .p1_wdata  (p1_wdata),
        .p1_ack    (p1_ack),
        .p1_err    (p1_err),
        .p1_rdata  (p1_rdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy_out  (busy_out)
    );

    always #5 clock = ~clock;

    // Bank model: one-cycle read latency
    always @(posedge clock) begin
        if (mem_we) begin
            we_count <= we_count + 1;
            if (mem_addr < 8'd140) bank[mem_addr] <= mem_wdata;
        end
        if (mem_re) begin
            re_count <= re_count + 1;
            if (mem_addr < 8'd140) mem_rdata <= bank[mem_addr];
        end
    end

    task automatic exp_seg(input int row, input int col, input logic [31:0] d);
        for (int b = 0; b < 32; b++)
            if (col + b < 140) exp_mem[row][col + b] = d[b];
    endtask

    task automatic issue(input logic port, input logic [1:0] op, input logic [7:0] row,
                         input logic [7:0] col, input logic [139:0] wdata,
                         output int lat, output logic err, output logic [139:0] rdata,
                         output logic busy_at_ack);
        logic acked;
        lat = 0; err = 1'b0; rdata = '0; busy_at_ack = 1'b0; acked = 1'b0;
        if (port) begin
            p1_op = op; p1_row = row; p1_col = col; p1_wdata = wdata; p1_valid = 1'b1;
        end else begin
            p0_op = op; p0_row = row; p0_col = col; p0_wdata = wdata; p0_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !acked; i++) begin
            @(posedge clock); #1;
            lat++;
            if (port ? p1_ack : p0_ack) begin
                acked       = 1'b1;
                err         = port ? p1_err : p0_err;
                rdata       = port ? p1_rdata : p0_rdata;
                busy_at_ack = busy_out;
            end
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        if (!acked) lat = -1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        @(posedge clock); #1;
        checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem_re: got %b want 0", mem_re); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        checks++; if ({p0_ack, p1_ack, p0_err, p1_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_ack_err: got %b want 0000", {p0_ack, p1_ack, p0_err, p1_err}); end
        checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 140'd0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (p0_rdata !== 140'd0 || p1_rdata !== 140'd0) begin
            errors++; $display("FAIL reset_rdata: got %h / %h want 0", p0_rdata, p1_rdata); end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_seg_write_readback;
        int lat; logic err, busy; logic [139:0] rd, want;
        issue(1'b0, OP_WR_SEG, 8'd3, 8'd32, {108'd0, 32'hFFFF_FFFF}, lat, err, rd, busy);
        exp_seg(3, 32, 32'hFFFF_FFFF);
        checks++; if (lat !== 4 || err !== 1'b0) begin
            errors++; $display("FAIL segwr_latency: got lat=%0d err=%b want lat=4 err=0", lat, err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL segwr_busy_at_ack: got %b want 1", busy); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL segwr_busy_fall: got %b want 0", busy_out); end
        issue(1'b1, OP_RD_ROW, 8'd3, 8'd0, '0, lat, err, rd, busy);
        want = '0;
        want[63:32] = 32'hFFFF_FFFF;
        checks++; if (lat !== 3 || err !== 1'b0) begin
            errors++; $display("FAIL rdrow_latency: got lat=%0d err=%b want lat=3 err=0", lat, err); end
        checks++; if (rd !== want) begin errors++; $display("FAIL rdrow_data: got %h want %h", rd, want); end
    endtask

    task automatic test_last_segment;
        int lat; logic err, busy; logic [139:0] rd, pat, want;
        pat = {12'h123, 64'hCAFE_BABE_DEAD_BEEF, 64'h0011_2233_4455_6677};
        issue(1'b1, OP_WR_ROW, 8'd0, 8'd0, pat, lat, err, rd, busy);
        exp_mem[0] = pat;
        checks++; if (lat !== 2 || err !== 1'b0) begin
            errors++; $display("FAIL wrrow_latency: got lat=%0d err=%b want lat=2 err=0", lat, err); end
        issue(1'b0, OP_WR_SEG, 8'd0, 8'd128, {108'd0, 32'hFFFF_FFFF}, lat, err, rd, busy);
        exp_seg(0, 128, 32'hFFFF_FFFF);
        want = {12'hFFF, pat[127:0]};
        checks++; if ($isunknown(mem_wdata)) begin errors++; $display("FAIL tailseg_wdata_x: got %h want no X", mem_wdata); end
        checks++; if (bank[0] !== want) begin errors++; $display("FAIL tailseg_bank: got %h want %h", bank[0], want); end
        issue(1'b1, OP_RD_ROW, 8'd0, 8'd0, '0, lat, err, rd, busy);
        checks++; if (rd !== want) begin errors++; $display("FAIL tailseg_readback: got %h want %h", rd, want); end
    endtask

    task automatic test_priority;
        int pad_cyc, core_cyc, n0, n1; logic [139:0] pat_a, pat_b, got;
        pat_a = {12'hABC, 64'h0123_4567_89AB_CDEF, 64'h1357_9BDF_0246_8ACE};
        pat_b = {12'h5A5, 64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978};
        // Pad writes row 5, core reads it back: core must see the pad data.
        pad_en = 1'b1;
        p0_op = OP_WR_ROW; p0_row = 8'd5; p0_wdata = pat_a; p0_valid = 1'b1;
        p1_op = OP_RD_ROW; p1_row = 8'd5; p1_wdata = '0;    p1_valid = 1'b1;
        pad_cyc = -1; core_cyc = -1; n0 = 0; n1 = 0; got = '0;
        for (int c = 1; c <= 20 && core_cyc < 0; c++) begin
            @(posedge clock); #1;
            if (p0_ack) begin n0++; pad_cyc = c; p0_valid = 1'b0; end
            if (p1_ack) begin n1++; core_cyc = c; got = p1_rdata; p1_valid = 1'b0; end
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        exp_mem[5] = pat_a;
        @(posedge clock); #1;
        checks++; if (pad_cyc !== 2 || core_cyc !== 6) begin
            errors++; $display("FAIL prio_pad_first: got pad=%0d core=%0d want pad=2 core=6", pad_cyc, core_cyc); end
        checks++; if (n0 !== 1 || n1 !== 1) begin
            errors++; $display("FAIL prio_ack_count: got p0=%0d p1=%0d want 1/1", n0, n1); end
        checks++; if (got !== pat_a) begin errors++; $display("FAIL prio_core_data: got %h want %h", got, pat_a); end
        // Without pad_en the core wins the tie.
        pad_en = 1'b0;
        p0_op = OP_RD_ROW; p0_row = 8'd6; p0_wdata = '0;    p0_valid = 1'b1;
        p1_op = OP_WR_ROW; p1_row = 8'd6; p1_wdata = pat_b; p1_valid = 1'b1;
        pad_cyc = -1; core_cyc = -1; got = '0;
        for (int c = 1; c <= 20 && pad_cyc < 0; c++) begin
            @(posedge clock); #1;
            if (p1_ack) begin core_cyc = c; p1_valid = 1'b0; end
            if (p0_ack) begin pad_cyc = c; got = p0_rdata; p0_valid = 1'b0; end
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        exp_mem[6] = pat_b;
        pad_en = 1'b1;
        @(posedge clock); #1;
        checks++; if (core_cyc !== 2 || pad_cyc !== 6) begin
            errors++; $display("FAIL prio_core_first: got core=%0d pad=%0d want core=2 pad=6", core_cyc, pad_cyc); end
        checks++; if (got !== pat_b) begin errors++; $display("FAIL prio_pad_data: got %h want %h", got, pat_b); end
    endtask

    task automatic test_reject;
        int lat, we0, re0; logic err, busy; logic [139:0] rd;
        we0 = we_count; re0 = re_count;
        issue(1'b0, OP_WR_SEG, 8'd3, 8'd16, {108'd0, 32'h1234_5678}, lat, err, rd, busy);
        checks++; if (lat !== 1 || err !== 1'b1) begin
            errors++; $display("FAIL reject_col: got lat=%0d err=%b want lat=1 err=1", lat, err); end
        issue(1'b1, OP_RD_ROW, 8'd140, 8'd0, '0, lat, err, rd, busy);
        checks++; if (lat !== 1 || err !== 1'b1) begin
            errors++; $display("FAIL reject_row: got lat=%0d err=%b want lat=1 err=1", lat, err); end
        checks++; if (we_count !== we0 || re_count !== re0) begin
            errors++; $display("FAIL reject_strobes: got we=%0d re=%0d want 0/0", we_count - we0, re_count - re0); end
        checks++; if (bank[3] !== exp_mem[3]) begin
            errors++; $display("FAIL reject_mem: got %h want %h", bank[3], exp_mem[3]); end
    endtask

    task automatic test_reset_mid_merge;
        int we0;
        we0 = we_count;
        p1_op = OP_WR_SEG; p1_row = 8'd7; p1_col = 8'd0; p1_wdata = {108'd0, 32'hDEAD_BEEF}; p1_valid = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if (busy_out !== 1'b0 || mem_we !== 1'b0 || p1_ack !== 1'b0) begin
            errors++; $display("FAIL midreset_immediate: got busy=%b we=%b ack=%b want 0 0 0", busy_out, mem_we, p1_ack); end
        p1_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        checks++; if (we_count !== we0) begin
            errors++; $display("FAIL midreset_no_write: got %0d writes want 0", we_count - we0); end
        checks++; if (bank[7] !== exp_mem[7]) begin
            errors++; $display("FAIL midreset_mem: got %h want %h", bank[7], exp_mem[7]); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL midreset_idle: got busy=%b want 0", busy_out); end
    endtask

    task automatic test_full_grid;
        int lat, bad_ops; logic err, busy; logic [139:0] rd; logic [31:0] d;
        bad_ops = 0;
        for (int r = 0; r < 140; r++) begin
            for (int s = 0; s < 5; s++) begin
                d = 32'h9E37_79B9 * 32'(r * 5 + s + 1);
                issue(1'b0, OP_WR_SEG, 8'(r), 8'(s * 32), {108'd0, d}, lat, err, rd, busy);
                exp_seg(r, s * 32, d);
                checks++;
                if (lat !== 4 || err !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    if (bad_ops < 8)
                        $display("FAIL grid_op r%0d s%0d: got lat=%0d err=%b busy=%b want 4 0 1", r, s, lat, err, busy);
                    bad_ops++;
                end
            end
        end
        for (int r = 0; r < 140; r++) begin
            checks++;
            if (bank[r] !== exp_mem[r]) begin
                errors++; $display("FAIL grid_row%0d: got %h want %h", r, bank[r], exp_mem[r]);
            end
        end
        issue(1'b1, OP_RD_ROW, 8'd139, 8'd0, '0, lat, err, rd, busy);
        checks++; if (rd !== exp_mem[139]) begin errors++; $display("FAIL grid_readback: got %h want %h", rd, exp_mem[139]); end
    endtask

    initial begin
        for (int r = 0; r < 140; r++) exp_mem[r] = '0;
        test_reset;
        test_seg_write_readback;
        test_last_segment;
        test_priority;
        test_reject;
        test_reset_mid_merge;
        test_full_grid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
